// File: rtl/result_collector_fifo.sv
// -----------------------------------------------------------------------------
// result_collector_fifo
//
// Merges result words from NUM_CE compute-engine channels into a single
// DEPTH-entry buffer using round-robin arbitration, and lets the host drain it
// through a registered read port with occupancy and error status.
//
// Optional feature macro: RESULT_TAG_EN
//   When defined, each entry also stores the index of the channel that wrote
//   it, and the o_rd_tag port returns that index alongside o_rd_data.
//
// Ports:
//   i_clk            clock
//   i_reset_n        synchronous active-low reset
//   i_clear          synchronous flush (pointers/count/arbiter only)
//   i_wr_data        NUM_CE packed result words, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_wr_valid       per-channel result valid
//   o_wr_ready       one-hot per-channel accept (combinational grant)
//   o_full           count == DEPTH
//   o_afull          count >= DEPTH-AFULL_MARGIN
//   i_rd_en          host pop request
//   o_rd_data        popped word, one cycle after i_rd_en
//   o_rd_valid       o_rd_data valid this cycle
//   o_empty          count == 0
//   o_count          current occupancy
//   o_result_count   total accepted writes (wraps)
//   o_overflow_err   sticky: a channel was valid while full
//   o_underflow_err  sticky: pop requested while empty
//   o_rd_tag         source channel of o_rd_data (RESULT_TAG_EN only)
// -----------------------------------------------------------------------------
module result_collector_fifo #(
  parameter int NUM_CE       = 4,
  parameter int DATA_WIDTH   = 24,
  parameter int DEPTH        = 16384,
  parameter int AFULL_MARGIN = 16,
  localparam int CNT_W       = $clog2(DEPTH) + 1,
  localparam int TAG_W       = (NUM_CE > 1) ? $clog2(NUM_CE) : 1
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic                         i_clear,
  input  logic [NUM_CE*DATA_WIDTH-1:0] i_wr_data,
  input  logic [NUM_CE-1:0]            i_wr_valid,
  output logic [NUM_CE-1:0]            o_wr_ready,
  output logic                         o_full,
  output logic                         o_afull,
  input  logic                         i_rd_en,
  output logic [DATA_WIDTH-1:0]        o_rd_data,
  output logic                         o_rd_valid,
  output logic                         o_empty,
  output logic [CNT_W-1:0]             o_count,
  output logic [15:0]                  o_result_count,
  output logic                         o_overflow_err,
  output logic                         o_underflow_err
`ifdef RESULT_TAG_EN
  ,
  output logic [TAG_W-1:0]             o_rd_tag
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);
`ifdef RESULT_TAG_EN
  localparam int ENTRY_W = DATA_WIDTH + TAG_W;
`else
  localparam int ENTRY_W = DATA_WIDTH;
`endif

  logic [NUM_CE-1:0]     grant;
  logic [TAG_W-1:0]      grant_idx;
  logic [TAG_W-1:0]      cand;
  logic                  found;
  logic [TAG_W-1:0]      rr_ptr;
  logic [DATA_WIDTH-1:0] wr_word;
  logic [ENTRY_W-1:0]    wr_entry;
  logic [ENTRY_W-1:0]    head;
  logic                  wr_en;
  logic                  rd_en;
  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_next;

  logic [ENTRY_W-1:0]    mem [DEPTH];

  // Round-robin search: first valid channel at or after rr_ptr, wrapping at NUM_CE.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_CE; i++) begin
      if ((int'(rr_ptr) + i) >= NUM_CE) begin
        cand = TAG_W'(int'(rr_ptr) + i - NUM_CE);
      end else begin
        cand = TAG_W'(int'(rr_ptr) + i);
      end
      if (!found && i_wr_valid[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end else begin
        found     = found;
      end
    end
    // A full buffer or a flush blocks every channel; the stalled channel keeps its data.
    if (found && !o_full && !i_clear) begin
      grant[grant_idx] = 1'b1;
    end else begin
      grant = '0;
    end
  end

  // Select the granted channel's word.
  always_comb begin
    wr_word = '0;
    for (int k = 0; k < NUM_CE; k++) begin
      if (grant[k]) begin
        wr_word = i_wr_data[k*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        wr_word = wr_word;
      end
    end
  end

`ifdef RESULT_TAG_EN
  assign wr_entry = {grant_idx, wr_word};
`else
  assign wr_entry = wr_word;
`endif

  assign o_wr_ready = grant;
  assign wr_en      = |grant;
  // A flush discards any same-cycle pop.
  assign rd_en      = i_rd_en & ~o_empty & ~i_clear;
  assign o_count    = count;
  assign head       = mem[rd_ptr];

  // Next occupancy; flags are registered from this so they track o_count exactly.
  always_comb begin
    count_next = count;
    if (i_clear) begin
      count_next = '0;
    end else begin
      count_next = count + CNT_W'(wr_en) - CNT_W'(rd_en);
    end
  end

  // Pointers, arbiter state, occupancy flags, counters and sticky errors.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      rr_ptr          <= '0;
      count           <= '0;
      o_full          <= 1'b0;
      o_afull         <= 1'b0;
      o_empty         <= 1'b1;
      o_result_count  <= 16'd0;
      o_overflow_err  <= 1'b0;
      o_underflow_err <= 1'b0;
    end else begin
      count   <= count_next;
      o_full  <= (count_next == CNT_W'(DEPTH));
      o_empty <= (count_next == CNT_W'(0));
      o_afull <= (count_next >= CNT_W'(DEPTH - AFULL_MARGIN));
      if (i_clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        rr_ptr <= '0;
      end else begin
        if (wr_en) begin
          // Power-of-two depth gives the pointer wrap for free.
          wr_ptr <= wr_ptr + ADDR_W'(1);
          rr_ptr <= (grant_idx == TAG_W'(NUM_CE - 1)) ? TAG_W'(0) : grant_idx + TAG_W'(1);
        end
        if (rd_en) begin
          rd_ptr <= rd_ptr + ADDR_W'(1);
        end
      end
      // Result counter and sticky errors survive a flush; only reset clears them.
      if (wr_en) begin
        o_result_count <= o_result_count + 16'd1;
      end
      if (o_full && (|i_wr_valid)) begin
        o_overflow_err <= 1'b1;
      end
      if (i_rd_en && o_empty) begin
        o_underflow_err <= 1'b1;
      end
    end
  end

  // Buffer storage write port.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Registered read port; data holds its last value when no pop happens.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_rd_valid <= 1'b0;
      o_rd_data  <= '0;
`ifdef RESULT_TAG_EN
      o_rd_tag   <= '0;
`endif
    end else begin
      o_rd_valid <= rd_en;
      if (rd_en) begin
        o_rd_data <= head[DATA_WIDTH-1:0];
`ifdef RESULT_TAG_EN
        o_rd_tag  <= head[ENTRY_W-1 -: TAG_W];
`endif
      end
    end
  end

endmodule

// File: tb/tb_result_collector_fifo.sv
// -----------------------------------------------------------------------------
// tb_result_collector_fifo
//
// Directed self-checking bench for result_collector_fifo with NUM_CE=4,
// DATA_WIDTH=24, DEPTH=16, AFULL_MARGIN=4. Inputs are driven 1 time unit after
// the rising edge; registered outputs are checked after the edge, the
// combinational grant is checked once inputs have settled.
// -----------------------------------------------------------------------------
module tb_result_collector_fifo;

  localparam int NCE = 4;
  localparam int DW  = 24;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            clear;
  logic [NCE*DW-1:0] wr_data;
  logic [NCE-1:0]  wr_valid;
  logic [NCE-1:0]  wr_ready;
  logic            full;
  logic            afull;
  logic            rd_en;
  logic [DW-1:0]   rd_data;
  logic            rd_valid;
  logic            empty;
  logic [4:0]      count;
  logic [15:0]     result_count;
  logic            ovf;
  logic            unf;
`ifdef RESULT_TAG_EN
  logic [1:0]      rd_tag;
`endif

  int tests = 0;
  int fails = 0;
  int exp_rc = 0;

  result_collector_fifo #(
    .NUM_CE(4), .DATA_WIDTH(24), .DEPTH(16), .AFULL_MARGIN(4)
  ) dut (
    .i_clk(clk),
    .i_reset_n(reset_n),
    .i_clear(clear),
    .i_wr_data(wr_data),
    .i_wr_valid(wr_valid),
    .o_wr_ready(wr_ready),
    .o_full(full),
    .o_afull(afull),
    .i_rd_en(rd_en),
    .o_rd_data(rd_data),
    .o_rd_valid(rd_valid),
    .o_empty(empty),
    .o_count(count),
    .o_result_count(result_count),
    .o_overflow_err(ovf),
    .o_underflow_err(unf)
`ifdef RESULT_TAG_EN
    ,
    .o_rd_tag(rd_tag)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [DW-1:0] v);
    wr_data[k*DW +: DW] = v;
  endtask

  task automatic do_clear;
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; clear = 1'b0; wr_data = '0; wr_valid = '0; rd_en = 1'b0;
    tick(); tick();
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b exp 1", empty); end
    tests++; if (full !== 1'b0 || afull !== 1'b0) begin fails++; $display("FAIL reset_full_afull got %b%b exp 00", full, afull); end
    tests++; if (count !== 5'd0 || result_count !== 16'd0) begin fails++; $display("FAIL reset_counts got %0d/%0d exp 0/0", count, result_count); end
    tests++; if (rd_valid !== 1'b0 || rd_data !== 24'h0) begin fails++; $display("FAIL reset_rd got %b/%h exp 0/000000", rd_valid, rd_data); end
    tests++; if (ovf !== 1'b0 || unf !== 1'b0) begin fails++; $display("FAIL reset_errs got %b%b exp 00", ovf, unf); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_fill;
    do_clear();
    wr_valid = 4'b0001;
    for (int k = 1; k <= 16; k++) begin
      set_ch(0, 24'(k));
      #1;
      tests++; if (wr_ready !== 4'b0001) begin fails++; $display("FAIL fill_ready[%0d] got %b exp 0001", k, wr_ready); end
      tick();
      exp_rc++;
      tests++; if (count !== 5'(k)) begin fails++; $display("FAIL fill_count[%0d] got %0d exp %0d", k, count, k); end
      tests++; if (full !== (k == 16)) begin fails++; $display("FAIL fill_full[%0d] got %b exp %b", k, full, (k == 16)); end
      tests++; if (afull !== (k >= 12)) begin fails++; $display("FAIL fill_afull[%0d] got %b exp %b", k, afull, (k >= 12)); end
    end
    set_ch(0, 24'h000011);
    #1;
    tests++; if (wr_ready !== 4'b0000) begin fails++; $display("FAIL stall_ready got %b exp 0000", wr_ready); end
    tick();
    tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL overflow_err got %b exp 1", ovf); end
    tests++; if (count !== 5'd16) begin fails++; $display("FAIL stall_count got %0d exp 16", count); end
    tests++; if (result_count !== 16'(exp_rc)) begin fails++; $display("FAIL fill_result_count got %0d exp %0d", result_count, exp_rc); end
    wr_valid = 4'b0000;
    rd_en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      tests++; if (rd_valid !== 1'b1 || rd_data !== 24'(k)) begin fails++; $display("FAIL drain[%0d] got %b/%h exp 1/%h", k, rd_valid, rd_data, 24'(k)); end
      tests++; if (count !== 5'(16 - k)) begin fails++; $display("FAIL drain_count[%0d] got %0d exp %0d", k, count, 16 - k); end
    end
    rd_en = 1'b0;
    tick();
    tests++; if (rd_valid !== 1'b0 || rd_data !== 24'h000010) begin fails++; $display("FAIL drain_hold got %b/%h exp 0/000010", rd_valid, rd_data); end
    tests++; if (empty !== 1'b1 || unf !== 1'b0) begin fails++; $display("FAIL drain_empty got %b/%b exp 1/0", empty, unf); end
  endtask

  task automatic test_round_robin;
    do_clear();
    for (int k = 0; k < NCE; k++) set_ch(k, 24'hA00000 + 24'(k));
    wr_valid = 4'b1111;
    for (int b = 0; b < 8; b++) begin
      #1;
      tests++; if (wr_ready !== (4'b0001 << (b % 4))) begin fails++; $display("FAIL rr_grant[%0d] got %b exp %b", b, wr_ready, 4'b0001 << (b % 4)); end
      tick();
      exp_rc++;
    end
    wr_valid = 4'b0000;
    tests++; if (count !== 5'd8) begin fails++; $display("FAIL rr_count got %0d exp 8", count); end
  endtask

  task automatic test_simultaneous;
    logic [DW-1:0] exp_d;
    logic [1:0]    exp_t;
    wr_valid = 4'b0010;
    rd_en = 1'b1;
    for (int j = 0; j < 10; j++) begin
      set_ch(1, 24'hB00000 + 24'(j));
      #1;
      tests++; if (wr_ready !== 4'b0010) begin fails++; $display("FAIL sim_grant[%0d] got %b exp 0010", j, wr_ready); end
      tick();
      exp_rc++;
      exp_d = (j < 8) ? 24'hA00000 + 24'(j % 4) : 24'hB00000 + 24'(j - 8);
      exp_t = (j < 8) ? 2'(j % 4) : 2'd1;
      tests++; if (count !== 5'd8) begin fails++; $display("FAIL sim_count[%0d] got %0d exp 8", j, count); end
      tests++; if (rd_valid !== 1'b1 || rd_data !== exp_d) begin fails++; $display("FAIL sim_data[%0d] got %b/%h exp 1/%h", j, rd_valid, rd_data, exp_d); end
`ifdef RESULT_TAG_EN
      tests++; if (rd_tag !== exp_t) begin fails++; $display("FAIL sim_tag[%0d] got %0d exp %0d", j, rd_tag, exp_t); end
`endif
    end
    wr_valid = 4'b0000;
    for (int j = 0; j < 8; j++) begin
      tick();
      exp_d = 24'hB00002 + 24'(j);
      tests++; if (rd_valid !== 1'b1 || rd_data !== exp_d) begin fails++; $display("FAIL wrap_data[%0d] got %b/%h exp 1/%h", j, rd_valid, rd_data, exp_d); end
    end
    rd_en = 1'b0;
    tick();
    tests++; if (empty !== 1'b1 || count !== 5'd0) begin fails++; $display("FAIL wrap_empty got %b/%0d exp 1/0", empty, count); end
  endtask

  task automatic test_full_concurrent;
    logic [DW-1:0] exp_d;
    do_clear();
    wr_valid = 4'b0001;
    for (int k = 0; k < 16; k++) begin
      set_ch(0, 24'hC00000 + 24'(k));
      tick();
      exp_rc++;
    end
    wr_valid = 4'b0010;
    set_ch(1, 24'hD00001);
    rd_en = 1'b1;
    #1;
    tests++; if (wr_ready !== 4'b0000) begin fails++; $display("FAIL fc_ready_full got %b exp 0000", wr_ready); end
    tick();
    rd_en = 1'b0;
    tests++; if (count !== 5'd15 || full !== 1'b0) begin fails++; $display("FAIL fc_count15 got %0d/%b exp 15/0", count, full); end
    tests++; if (rd_valid !== 1'b1 || rd_data !== 24'hC00000) begin fails++; $display("FAIL fc_read got %b/%h exp 1/c00000", rd_valid, rd_data); end
    #1;
    tests++; if (wr_ready !== 4'b0010) begin fails++; $display("FAIL fc_ready_next got %b exp 0010", wr_ready); end
    tick();
    exp_rc++;
    wr_valid = 4'b0000;
    tests++; if (count !== 5'd16 || full !== 1'b1) begin fails++; $display("FAIL fc_count16 got %0d/%b exp 16/1", count, full); end
    rd_en = 1'b1;
    for (int j = 0; j < 16; j++) begin
      tick();
      exp_d = (j < 15) ? 24'hC00001 + 24'(j) : 24'hD00001;
      tests++; if (rd_data !== exp_d) begin fails++; $display("FAIL fc_drain[%0d] got %h exp %h", j, rd_data, exp_d); end
    end
    rd_en = 1'b0;
    tick();
  endtask

  task automatic test_underflow_clear;
    do_clear();
    tests++; if (unf !== 1'b0) begin fails++; $display("FAIL unf_before got %b exp 0", unf); end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    tests++; if (unf !== 1'b1 || rd_valid !== 1'b0) begin fails++; $display("FAIL underflow got %b/%b exp 1/0", unf, rd_valid); end
    wr_valid = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      set_ch(0, 24'hE00000 + 24'(k));
      tick();
      exp_rc++;
    end
    tests++; if (count !== 5'd5) begin fails++; $display("FAIL clr_pre_count got %0d exp 5", count); end
    set_ch(0, 24'hE00005);
    clear = 1'b1;
    rd_en = 1'b1;
    #1;
    tests++; if (wr_ready !== 4'b0000) begin fails++; $display("FAIL clr_ready got %b exp 0000", wr_ready); end
    tick();
    clear = 1'b0; rd_en = 1'b0; wr_valid = 4'b0000;
    tests++; if (count !== 5'd0 || empty !== 1'b1) begin fails++; $display("FAIL clr_count got %0d/%b exp 0/1", count, empty); end
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL clr_rd_valid got %b exp 0", rd_valid); end
    tests++; if (result_count !== 16'(exp_rc)) begin fails++; $display("FAIL clr_result_count got %0d exp %0d", result_count, exp_rc); end
    tests++; if (ovf !== 1'b1 || unf !== 1'b1) begin fails++; $display("FAIL clr_errs got %b%b exp 11", ovf, unf); end
  endtask

  task automatic test_reset_mid;
    do_clear();
    wr_valid = 4'b1111;
    for (int k = 0; k < 9; k++) tick();
    tests++; if (count !== 5'd9) begin fails++; $display("FAIL mid_pre_count got %0d exp 9", count); end
    reset_n = 1'b0;
    rd_en = 1'b1;
    tick();
    tests++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || afull !== 1'b0) begin fails++; $display("FAIL mid_flags got %0d/%b%b%b exp 0/100", count, empty, full, afull); end
    tests++; if (result_count !== 16'd0) begin fails++; $display("FAIL mid_result_count got %0d exp 0", result_count); end
    tests++; if (rd_valid !== 1'b0 || rd_data !== 24'h0) begin fails++; $display("FAIL mid_rd got %b/%h exp 0/000000", rd_valid, rd_data); end
    tests++; if (ovf !== 1'b0 || unf !== 1'b0) begin fails++; $display("FAIL mid_errs got %b%b exp 00", ovf, unf); end
`ifdef RESULT_TAG_EN
    tests++; if (rd_tag !== 2'd0) begin fails++; $display("FAIL mid_tag got %0d exp 0", rd_tag); end
`endif
    reset_n = 1'b1;
    rd_en = 1'b0;
    #1;
    tests++; if (wr_ready !== 4'b0001) begin fails++; $display("FAIL mid_rr_restart got %b exp 0001", wr_ready); end
    wr_valid = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_fill();
    test_round_robin();
    test_simultaneous();
    test_full_concurrent();
    test_underflow_clear();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
